// File: rtl/gen_pulse_shaper.sv
// gen_pulse_shaper: synthetic ADC pulse source with linear rise and exponential decay.
// Define PULSE_NOISE_EN to add LFSR noise onto y; by default y is the accumulator.
module gen_pulse_shaper #(
  parameter int W          = 14,
  parameter int SEL_W      = 4,
  parameter int P_W        = 16,
  parameter int RISE_LOG2  = 0,
  parameter int NOISE_BITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [W-1:0]     val,
  input  logic [SEL_W-1:0] sel,
  input  logic [P_W-1:0]   period,
  input  logic             trig,
  output logic [W-1:0]     y,
  output logic             busy,
  output logic             pileup
);

  typedef enum logic [1:0] {
    IDLE,
    RISE,
    DECAY
  } state_e;

  localparam logic [7:0] RiseLast = 8'((1 << RISE_LOG2) - 1);

  function automatic logic signed [W-1:0] sat(input logic signed [W:0] s);
    if (s[W] != s[W-1])
      sat = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      sat = s[W-1:0];
  endfunction

  state_e              state_q, state_d;
  logic signed [W-1:0] amp_q;
  logic signed [W-1:0] acc_q, acc_d;
  logic signed [W-1:0] tgt_q, tgt_d;
  logic signed [W-1:0] step_q, step_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [P_W-1:0]      pcnt_q, pcnt_d;
  logic                pile_q, pile_d;

  logic                tick, trg;
  logic signed [W-1:0] peak, stepn, dec;
  logic signed [W:0]   diff, diff_sh;

  // Auto tick on the last count of the period; load restarts and suppresses it.
  assign tick = (period != '0) && !load
              && (pcnt_q == period - P_W'(1));
  assign trg  = trig | tick;

  assign peak    = sat({acc_q[W-1], acc_q} + {amp_q[W-1], amp_q});
  assign diff    = {peak[W-1], peak} - {acc_q[W-1], acc_q};
  assign diff_sh = diff >>> RISE_LOG2;
  assign stepn   = diff_sh[W-1:0];
  assign dec     = acc_q >>> sel;

  // Period counter: wraps on the tick, cleared by load or a zero period.
  always_comb begin
    pcnt_d = pcnt_q + P_W'(1);
    if (load || period == '0 || pcnt_q == period - P_W'(1))
      pcnt_d = '0;
  end

  // Pulse FSM: next state, accumulator and rise parameters.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    pile_d  = trg && (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (trg) begin
          tgt_d   = peak;
          step_d  = stepn;
          cnt_d   = '0;
          state_d = RISE;
        end
      end
      RISE: begin
        if (cnt_q == RiseLast) begin
          acc_d   = tgt_q;
          state_d = DECAY;
        end else begin
          acc_d = acc_q + step_q;
          cnt_d = cnt_q + 8'd1;
        end
      end
      DECAY: begin
        if (trg) begin
          tgt_d   = peak;
          step_d  = stepn;
          cnt_d   = '0;
          state_d = RISE;
        end else if (sel != '0) begin
          if (dec == '0) begin
            acc_d   = '0;
            state_d = IDLE;
          end else begin
            acc_d = acc_q - dec;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      amp_q   <= '0;
      acc_q   <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      pile_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      pile_q  <= pile_d;
      if (load)
        amp_q <= val;
    end
  end

  assign busy   = (state_q != IDLE);
  assign pileup = pile_q;

`ifdef PULSE_NOISE_EN
  logic [15:0]         lfsr_q;
  logic [W-1:0]        y_q;
  logic signed [W-1:0] noise;

  assign noise = W'($signed(lfsr_q[NOISE_BITS-1:0]));

  // Noise source and noisy output sample; pulse state never sees the noise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
      y_q    <= '0;
    end else begin
      lfsr_q <= {lfsr_q[14:0],
                 lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      y_q    <= sat({acc_d[W-1], acc_d} + {noise[W-1], noise});
    end
  end

  assign y = y_q;
`else
  assign y = acc_q;
`endif

endmodule

// File: tb/tb_gen_pulse_shaper.sv
// Bench for gen_pulse_shaper: two instances (rise 1 and 4 cycles) against a
// pulse-list model, plus hand-computed waveform points.
module tb_gen_pulse_shaper;

  localparam int W    = 14;
  localparam int VMAX = 8191;
  localparam int VMIN = -8192;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          load   = 1'b0;
  logic          trig   = 1'b0;
  logic [W-1:0]  val    = '0;
  logic [3:0]    sel    = '0;
  logic [15:0]   period = '0;
  logic [W-1:0]  y0, y1;
  logic          busy0, busy1, pile0, pile1;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  gen_pulse_shaper u0 (
    .clk(clk), .rst_n(rst_n), .load(load), .val(val), .sel(sel),
    .period(period), .trig(trig), .y(y0), .busy(busy0), .pileup(pile0)
  );

  gen_pulse_shaper #(.RISE_LOG2(2)) u1 (
    .clk(clk), .rst_n(rst_n), .load(load), .val(val), .sel(sel),
    .period(period), .trig(trig), .y(y1), .busy(busy1), .pileup(pile1)
  );

  function automatic int sy(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int satw(input int s);
    if (s > VMAX) return VMAX;
    if (s < VMIN) return VMIN;
    return s;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: each pulse is a precomputed list of rise samples, then decay.
  int m_acc[2];
  bit m_busy[2];
  bit m_pile[2];
  int m_rv[2][128];
  int m_rn[2];
  int m_rp[2];
  int m_amp;
  int m_pc;

  task automatic model_inst(input int i, input bit tg);
    int rl, n, tgt, stp, d;
    rl = (i == 0) ? 0 : 2;
    n  = 1 << rl;
    m_pile[i] = tg && m_busy[i];
    if (tg && (!m_busy[i] || m_rp[i] >= m_rn[i])) begin
      tgt = satw(m_acc[i] + m_amp);
      stp = (tgt - m_acc[i]) >>> rl;
      for (int k = 1; k < n; k++)
        m_rv[i][k-1] = m_acc[i] + k * stp;
      m_rv[i][n-1] = tgt;
      m_rn[i] = n;
      m_rp[i] = 0;
      m_busy[i] = 1'b1;
    end else if (m_rp[i] < m_rn[i]) begin
      m_acc[i] = m_rv[i][m_rp[i]];
      m_rp[i]++;
    end else if (m_busy[i] && sel != 0) begin
      d = m_acc[i] >>> sel;
      if (d == 0) begin
        m_acc[i] = 0;
        m_busy[i] = 1'b0;
      end else begin
        m_acc[i] = m_acc[i] - d;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit tk;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_acc[i] = 0; m_busy[i] = 0; m_pile[i] = 0;
        m_rn[i] = 0; m_rp[i] = 0;
      end
      m_amp = 0;
      m_pc  = 0;
    end else begin
      tk = (period != 0) && !load && (m_pc == int'(period) - 1);
      model_inst(0, trig || tk);
      model_inst(1, trig || tk);
      if (load) m_amp = sy(val);
      if (load || period == 0 || m_pc == int'(period) - 1) m_pc = 0;
      else m_pc = m_pc + 1;
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_y0", sy(y0), m_acc[0]);
      chk("m_busy0", int'(busy0), int'(m_busy[0]));
      chk("m_pile0", int'(pile0), int'(m_pile[0]));
      chk("m_y1", sy(y1), m_acc[1]);
      chk("m_busy1", int'(busy1), int'(m_busy[1]));
      chk("m_pile1", int'(pile1), int'(m_pile[1]));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while ((busy0 || busy1) && n < maxc) begin
      cyc();
      n++;
    end
    chk("idle_timeout", int'(busy0 || busy1), 0);
  endtask

  initial begin
    repeat (3) cyc();
    chk("rst_y", sy(y0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_pile", int'(pile0), 0);
    rst_n = 1'b1;
    cyc();
    cmp_en = 1'b1;

    // Full-scale pulse, sel=10
    load = 1; val = 14'd8191; sel = 4'd10; cyc();
    load = 0; trig = 1; cyc();
    trig = 0;
    chk("t1_busy", int'(busy0), 1);
    chk("t1_y_e0", sy(y0), 0);
    cyc(); chk("t1_peak", sy(y0), 8191);
    cyc(); chk("t1_d1", sy(y0), 8184);
    cyc(); chk("t1_d2", sy(y0), 8177);
    wait_idle(6000);
    chk("t1_end_y", sy(y0), 0);

    // Pile-up during decay
    trig = 1; cyc();
    trig = 0; cyc(); chk("t3_peak", sy(y0), 8191);
    cyc(); chk("t3_d1", sy(y0), 8184);
    trig = 1; cyc();
    trig = 0;
    chk("t3_pile", int'(pile0), 1);
    chk("t3_hold", sy(y0), 8184);
    cyc();
    chk("t3_pile_off", int'(pile0), 0);
    chk("t3_sat", sy(y0), 8191);
    cyc(); chk("t3_redecay", sy(y0), 8184);
    wait_idle(6000);

    // Negative full-scale, 4-cycle rise on u1
    load = 1; val = 14'h2000; sel = 4'd4; cyc();
    load = 0; trig = 1; cyc();
    trig = 0;
    cyc(); chk("t2_r1", sy(y1), -2048); chk("t2_u0pk", sy(y0), -8192);
    cyc(); chk("t2_r2", sy(y1), -4096);
    cyc(); chk("t2_r3", sy(y1), -6144);
    cyc(); chk("t2_r4", sy(y1), -8192);
    wait_idle(2000);
    chk("t2_end_y1", sy(y1), 0);

    // Auto trigger every 5 cycles
    period = 16'd5; load = 1; val = 14'd1000; sel = 4'd2; cyc();
    load = 0;
    repeat (4) cyc(); chk("t4_quiet", int'(busy0), 0);
    cyc(); chk("t4_tick", int'(busy0), 1);
    cyc(); chk("t4_peak", sy(y0), 1000);
    cyc(); chk("t4_d1", sy(y0), 750);
    cyc(); chk("t4_d2", sy(y0), 563);
    cyc(); chk("t4_d3", sy(y0), 423);
    cyc();
    chk("t4_pile", int'(pile0), 1);
    chk("t4_hold", sy(y0), 423);
    cyc(); chk("t4_pk2", sy(y0), 1423);
    repeat (20) cyc();
    period = '0;
    wait_idle(500);
    repeat (20) cyc();
    chk("t4_off0", int'(busy0), 0);
    chk("t4_off1", int'(busy1), 0);

    // Flat top, sel=0
    load = 1; val = 14'd500; sel = 4'd0; cyc();
    load = 0; trig = 1; cyc();
    trig = 0; cyc(); chk("t5_peak", sy(y0), 500);
    repeat (10) cyc();
    chk("t5_hold0", sy(y0), 500);
    chk("t5_hold1", sy(y1), 500);
    chk("t5_busy", int'(busy0), 1);
    trig = 1; cyc();
    trig = 0; cyc(); chk("t5_stack0", sy(y0), 1000);
    repeat (3) cyc(); chk("t5_stack1", sy(y1), 1000);

    // Asynchronous reset mid-decay with pileup high
    sel = 4'd8;
    repeat (5) cyc();
    chk("t6_busy", int'(busy0), 1);
    trig = 1;
    @(posedge clk);
    #2;
    chk("t6_pile_pre", int'(pile0), 1);
    trig = 0;
    cmp_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_y0", sy(y0), 0);
    chk("t6_busy0", int'(busy0), 0);
    chk("t6_pile0", int'(pile0), 0);
    chk("t6_y1", sy(y1), 0);
    chk("t6_busy1", int'(busy1), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    cmp_en = 1'b1;
    trig = 1; cyc();
    trig = 0;
    repeat (6) cyc();
    chk("t6_zero0", sy(y0), 0);
    chk("t6_zero1", sy(y1), 0);
    wait_idle(50);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
